// File: rtl/video_timing_gen_multimode.sv
// Multi-mode raster timing generator. It selects per-mode limits from a parameter table,
// switches modes only at frame boundaries, and registers all sync, de, coordinate and strobe outputs.
module video_timing_gen_multimode #(
    parameter int NMODES = 2,
    parameter int CW     = 12,
    parameter int H_ACTIVE [NMODES] = '{32'd1280, 32'd640},
    parameter int H_FP     [NMODES] = '{32'd110,  32'd16},
    parameter int H_SW     [NMODES] = '{32'd40,   32'd96},
    parameter int H_BP     [NMODES] = '{32'd220,  32'd48},
    parameter int V_ACTIVE [NMODES] = '{32'd720,  32'd480},
    parameter int V_FP     [NMODES] = '{32'd5,    32'd10},
    parameter int V_SW     [NMODES] = '{32'd5,    32'd2},
    parameter int V_BP     [NMODES] = '{32'd20,   32'd33},
    parameter bit HS_POL   [NMODES] = '{1'b1, 1'b0},
    parameter bit VS_POL   [NMODES] = '{1'b1, 1'b0},
    parameter int X_SCALE  = 0,
    parameter int Y_SCALE  = 0,
    localparam int MW = (NMODES > 1) ? $clog2(NMODES) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic [MW-1:0] mode_sel_i,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic [CW-1:0] x_scaled_o,
    output logic [CW-1:0] y_scaled_o,
    output logic          frame_start_o,
    output logic          line_start_o,
    output logic [MW-1:0] cur_mode_o,
    output logic          mode_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] h_r, v_r, h_s, v_s;
    logic [MW-1:0] cur_mode_r, cur_mode_s;
    logic [MW-1:0] pend_mode_r, pend_mode_s;
    logic          pend_valid_r, pend_valid_s;
    logic          sel_valid_s, sel_err_s, wrap_s, apply_s;

    logic [CW-1:0] h_act_s, hs_beg_s, hs_end_s, h_last_s;
    logic [CW-1:0] v_act_s, vs_beg_s, vs_end_s, v_last_s;
    logic          hs_pol_s, vs_pol_s;
    logic          run_s, de_s, hs_act_s, vs_act_s, fs_s, ls_s;

    // Region limits of the mode currently driving the raster
    always_comb begin
        h_act_s  = CW'(H_ACTIVE[cur_mode_r]);
        hs_beg_s = CW'(H_ACTIVE[cur_mode_r] + H_FP[cur_mode_r]);
        hs_end_s = CW'(H_ACTIVE[cur_mode_r] + H_FP[cur_mode_r] + H_SW[cur_mode_r]);
        h_last_s = CW'(H_ACTIVE[cur_mode_r] + H_FP[cur_mode_r] + H_SW[cur_mode_r]
                       + H_BP[cur_mode_r] - 32'sd1);
        v_act_s  = CW'(V_ACTIVE[cur_mode_r]);
        vs_beg_s = CW'(V_ACTIVE[cur_mode_r] + V_FP[cur_mode_r]);
        vs_end_s = CW'(V_ACTIVE[cur_mode_r] + V_FP[cur_mode_r] + V_SW[cur_mode_r]);
        v_last_s = CW'(V_ACTIVE[cur_mode_r] + V_FP[cur_mode_r] + V_SW[cur_mode_r]
                       + V_BP[cur_mode_r] - 32'sd1);
        hs_pol_s = HS_POL[cur_mode_r];
        vs_pol_s = VS_POL[cur_mode_r];
    end

    // Mode request tracking; the current cycle's sample takes part in an apply on this edge
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_err_s    = 1'b0;
        pend_valid_s = pend_valid_r;
        pend_mode_s  = pend_mode_r;
        cur_mode_s   = cur_mode_r;
        if (NMODES > 1) begin
            if (32'(mode_sel_i) < 32'(NMODES)) begin
                sel_valid_s = 1'b1;
            end else begin
                sel_err_s = 1'b1;
            end
        end else begin
            sel_valid_s = 1'b0;
        end
        if (sel_valid_s) begin
            if (mode_sel_i != cur_mode_r) begin
                pend_valid_s = 1'b1;
                pend_mode_s  = mode_sel_i;
            end else begin
                pend_valid_s = 1'b0;
            end
        end else begin
            pend_valid_s = pend_valid_r;
        end
        wrap_s  = (state_r == ST_RUN) && (h_r == h_last_s) && (v_r == v_last_s);
        apply_s = pend_valid_s && ((state_r == ST_IDLE) || wrap_s);
        if (apply_s) begin
            cur_mode_s   = pend_mode_s;
            pend_valid_s = 1'b0;
        end else begin
            cur_mode_s = cur_mode_r;
        end
    end

    // Raster FSM next state and counter advance; a disable aborts the frame at once
    always_comb begin
        state_s = state_r;
        h_s     = h_r;
        v_s     = v_r;
        case (state_r)
            ST_IDLE: begin
                h_s = {CW{1'b0}};
                v_s = {CW{1'b0}};
                if (enable_i) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_s = ST_IDLE;
                    h_s     = {CW{1'b0}};
                    v_s     = {CW{1'b0}};
                end else if (h_r == h_last_s) begin
                    h_s = {CW{1'b0}};
                    if (v_r == v_last_s) begin
                        v_s = {CW{1'b0}};
                    end else begin
                        v_s = v_r + CW'(1'b1);
                    end
                end else begin
                    h_s = h_r + CW'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                h_s     = {CW{1'b0}};
                v_s     = {CW{1'b0}};
            end
        endcase
    end

    // Output decode of the present counter position
    always_comb begin
        run_s    = (state_r == ST_RUN);
        de_s     = run_s && (h_r < h_act_s) && (v_r < v_act_s);
        hs_act_s = run_s && (h_r >= hs_beg_s) && (h_r < hs_end_s);
        vs_act_s = run_s && (v_r >= vs_beg_s) && (v_r < vs_end_s);
        fs_s     = run_s && (h_r == {CW{1'b0}}) && (v_r == {CW{1'b0}});
        ls_s     = run_s && (h_r == {CW{1'b0}});
    end

    // Raster state, counters and mode bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            h_r          <= {CW{1'b0}};
            v_r          <= {CW{1'b0}};
            cur_mode_r   <= {MW{1'b0}};
            pend_mode_r  <= {MW{1'b0}};
            pend_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            h_r          <= h_s;
            v_r          <= v_s;
            cur_mode_r   <= cur_mode_s;
            pend_mode_r  <= pend_mode_s;
            pend_valid_r <= pend_valid_s;
        end
    end

    // Registered outputs, one cycle behind the counter position they describe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_o          <= ~HS_POL[0];
            vs_o          <= ~VS_POL[0];
            de_o          <= 1'b0;
            x_o           <= {CW{1'b0}};
            y_o           <= {CW{1'b0}};
            x_scaled_o    <= {CW{1'b0}};
            y_scaled_o    <= {CW{1'b0}};
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
            cur_mode_o    <= {MW{1'b0}};
            mode_err_o    <= 1'b0;
        end else begin
            hs_o          <= hs_act_s ? hs_pol_s : ~hs_pol_s;
            vs_o          <= vs_act_s ? vs_pol_s : ~vs_pol_s;
            de_o          <= de_s;
            x_o           <= h_r;
            y_o           <= v_r;
            x_scaled_o    <= h_r >> X_SCALE;
            y_scaled_o    <= v_r >> Y_SCALE;
            frame_start_o <= fs_s;
            line_start_o  <= ls_s;
            cur_mode_o    <= cur_mode_s;
            mode_err_o    <= mode_err_o | sel_err_s;
        end
    end

endmodule

// File: tb/tb_video_timing_gen_multimode.sv
// Bench for video_timing_gen_multimode: scenario tasks plus random stimulus, checked against
// a frame-position reference model (linear pixel index within the frame).
module tb_video_timing_gen_multimode;

    localparam int NM   = 3;
    localparam int CW   = 8;
    localparam int MW   = 2;
    localparam int HA [NM] = '{8, 4, 5};
    localparam int HF [NM] = '{2, 1, 1};
    localparam int HW [NM] = '{2, 1, 2};
    localparam int HB [NM] = '{2, 1, 1};
    localparam int VA [NM] = '{4, 2, 3};
    localparam int VF [NM] = '{1, 1, 1};
    localparam int VW [NM] = '{1, 1, 1};
    localparam int VB [NM] = '{1, 1, 2};
    localparam bit HP [NM] = '{1'b1, 1'b0, 1'b1};
    localparam bit VP [NM] = '{1'b1, 1'b0, 1'b0};
    localparam int XS   = 1;
    localparam int YS   = 1;
    localparam int OUTW = 3 + 4 * CW + 2 + MW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [MW-1:0] mode_sel = 2'd0;
    logic          hs, vs, de, fs, ls, err;
    logic [CW-1:0] x, y, xs, ys;
    logic [MW-1:0] cur;
    logic [OUTW-1:0] dut_vec, exp_vec, rst_vec;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: running flag, linear position in frame, mode, pending request, error
    bit m_run, m_pv, m_err;
    int m_pos, m_mode, m_pm;

    always #5 clk = ~clk;

    video_timing_gen_multimode #(
        .NMODES(NM), .CW(CW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SW(HW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SW(VW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .X_SCALE(XS), .Y_SCALE(YS)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_sel_i(mode_sel),
        .hs_o(hs), .vs_o(vs), .de_o(de), .x_o(x), .y_o(y),
        .x_scaled_o(xs), .y_scaled_o(ys), .frame_start_o(fs), .line_start_o(ls),
        .cur_mode_o(cur), .mode_err_o(err)
    );

    assign dut_vec = {hs, vs, de, x, y, xs, ys, fs, ls, cur, err};

    function automatic int ht(int m);
        return HA[m] + HF[m] + HW[m] + HB[m];
    endfunction

    function automatic int vt(int m);
        return VA[m] + VF[m] + VW[m] + VB[m];
    endfunction

    function automatic int m_h();
        return m_pos % ht(m_mode);
    endfunction

    function automatic int m_v();
        return m_pos / ht(m_mode);
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pv = 1'b0; m_err = 1'b0;
        m_pos = 0; m_mode = 0; m_pm = 0;
    endtask

    // expected outputs after the coming edge, then advance the model by one pixel clock
    task automatic model_step();
        int h, v, tot, sel;
        bit o_hs, o_vs, o_de, o_fs, o_ls, run0, wrap;
        h   = m_h();
        v   = m_v();
        tot = ht(m_mode) * vt(m_mode);
        sel = int'(mode_sel);
        o_de = m_run && h < HA[m_mode] && v < VA[m_mode];
        o_hs = (m_run && h >= HA[m_mode] + HF[m_mode] && h < HA[m_mode] + HF[m_mode] + HW[m_mode])
               ? HP[m_mode] : !HP[m_mode];
        o_vs = (m_run && v >= VA[m_mode] + VF[m_mode] && v < VA[m_mode] + VF[m_mode] + VW[m_mode])
               ? VP[m_mode] : !VP[m_mode];
        o_fs = m_run && m_pos == 0;
        o_ls = m_run && h == 0;
        if (sel >= NM) m_err = 1'b1;
        else if (sel != m_mode) begin m_pv = 1'b1; m_pm = sel; end
        else m_pv = 1'b0;
        run0 = m_run;
        wrap = m_run && m_pos == tot - 1;
        if (run0) begin
            if (!enable) begin m_run = 1'b0; m_pos = 0; end
            else m_pos = (m_pos + 1) % tot;
        end else begin
            m_run = enable;
            m_pos = 0;
        end
        if (m_pv && (!run0 || wrap)) begin m_mode = m_pm; m_pv = 1'b0; end
        exp_vec = {o_hs, o_vs, o_de, CW'(h), CW'(v), CW'(h >> XS), CW'(v >> YS),
                   o_fs, o_ls, MW'(m_mode), m_err};
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; mode_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        if (dut_vec !== rst_vec) begin
            $display("FAIL reset got=%h exp=%h", dut_vec, rst_vec); n_bad++;
        end
        n_vec++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_m0_frame();
        int first_fs = -1, last_fs = -1, de_cnt = 0;
        enable = 1'b1; mode_sel = 2'd0;
        for (int i = 0; i < 2 * 98 + 6; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL m0_frame i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
            if (fs === 1'b1) begin
                if (first_fs < 0) begin
                    first_fs = i;
                    if (first_fs != 1) begin
                        $display("FAIL first_fs got=%0d exp=1", first_fs); n_bad++;
                    end
                    n_vec++;
                end else begin
                    if (i - last_fs != 98 || de_cnt != 32) begin
                        $display("FAIL m0_period got=%0d/%0d exp=98/32", i - last_fs, de_cnt); n_bad++;
                    end
                    n_vec++;
                end
                last_fs = i; de_cnt = 0;
            end
            if (de === 1'b1) de_cnt++;
        end
        if (first_fs < 0) begin $display("FAIL m0_no_frame_start"); n_bad++; n_vec++; end
    endtask

    task automatic test_mode_switch();
        int k = 0, last_fs = -1, got = 0;
        while (!(m_run && m_mode == 0 && m_h() == 3 && m_v() == 2) && k < 300) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL switch_pre got=%h exp=%h", dut_vec, exp_vec); n_bad++;
            end
            n_vec++; k++;
        end
        mode_sel = 2'd1;
        for (int i = 0; i < 400 && got < 2; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL switch i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
            if (fs === 1'b1) begin
                if (cur !== 2'd1) begin $display("FAIL switch_cur got=%0d exp=1", cur); n_bad++; end
                n_vec++;
                if (last_fs >= 0) begin
                    if (i - last_fs != 35) begin
                        $display("FAIL m1_period got=%0d exp=35", i - last_fs); n_bad++;
                    end
                    n_vec++;
                end
                last_fs = i; got++;
            end
        end
        if (got < 2) begin $display("FAIL switch_timeout got=%0d exp=2", got); n_bad++; n_vec++; end
    endtask

    task automatic test_invalid();
        mode_sel = 2'd3;
        for (int i = 0; i < 45; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL invalid i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
        end
        mode_sel = 2'd1;
        repeat (5) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL invalid_after got=%h exp=%h", dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
        end
        if (err !== 1'b1 || cur !== 2'd1) begin
            $display("FAIL invalid_sticky got=%b/%0d exp=1/1", err, cur); n_bad++;
        end
        n_vec++;
    endtask

    task automatic test_disable();
        int k = 0;
        mode_sel = 2'd0;
        while (!(m_run && m_mode == 0 && m_h() == 6 && m_v() == 2) && k < 400) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL disable_pre got=%h exp=%h", dut_vec, exp_vec); n_bad++;
            end
            n_vec++; k++;
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL disable i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
            if (i == 1) begin
                if ({de, hs, vs} !== 3'b000 || x !== 8'd0 || y !== 8'd0) begin
                    $display("FAIL idle_out got=%b%b%b x=%0d y=%0d exp=000 0 0", de, hs, vs, x, y);
                    n_bad++;
                end
                n_vec++;
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL reenable i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
        end
        if (fs !== 1'b1) begin $display("FAIL reenable_fs got=%b exp=1", fs); n_bad++; end
        n_vec++;
    endtask

    task automatic test_scale();
        int seen = 0, ls_cnt = 0;
        bit hit = 1'b0;
        for (int i = 0; i < 250 && seen < 2; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL scale i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
            if (fs === 1'b1) begin
                if (seen == 1) begin
                    if (ls_cnt != 7) begin $display("FAIL line_count got=%0d exp=7", ls_cnt); n_bad++; end
                    n_vec++;
                end
                seen++; ls_cnt = 0;
            end
            if (ls === 1'b1) ls_cnt++;
            if (de === 1'b1 && x == 8'd7 && y == 8'd3) begin
                hit = 1'b1;
                if (xs !== 8'd3 || ys !== 8'd1) begin
                    $display("FAIL scaled got=%0d/%0d exp=3/1", xs, ys); n_bad++;
                end
                n_vec++;
            end
        end
        if (seen < 2 || !hit) begin $display("FAIL scale_timeout seen=%0d hit=%b", seen, hit); n_bad++; n_vec++; end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            enable = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 39) == 0) mode_sel = MW'($urandom_range(0, 3));
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        enable = 1'b1; mode_sel = 2'd0;
        while (!(m_run && m_mode == 0 && m_pos == 10) && k < 600) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL rstmid_pre got=%h exp=%h", dut_vec, exp_vec); n_bad++;
            end
            n_vec++; k++;
        end
        mode_sel = 2'd1;
        cycle();
        if (dut_vec !== exp_vec) begin
            $display("FAIL rstmid_req got=%h exp=%h", dut_vec, exp_vec); n_bad++;
        end
        n_vec++;
        mode_sel = 2'd3;
        #2 rst = 1'b1;
        #1;
        if (dut_vec !== rst_vec) begin
            $display("FAIL async_reset got=%h exp=%h", dut_vec, rst_vec); n_bad++;
        end
        n_vec++;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (dut_vec !== exp_vec) begin
                $display("FAIL rstmid_post i=%0d got=%h exp=%h", i, dut_vec, exp_vec); n_bad++;
            end
            n_vec++;
        end
        if (cur !== 2'd0) begin $display("FAIL pending_discard got=%0d exp=0", cur); n_bad++; end
        n_vec++;
    endtask

    initial begin
        rst_vec = {!HP[0], !VP[0], 1'b0, {(4 * CW){1'b0}}, 2'b00, {MW{1'b0}}, 1'b0};
        model_reset();
        test_reset();
        test_m0_frame();
        test_mode_switch();
        test_invalid();
        test_disable();
        test_scale();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
